// File: rtl/qkd_pkg.sv
// rtl/qkd_pkg.sv - shared types and constants for the QKD buffer writer
// Symbol layout {basis, value}, packing geometry, length width and the bank FSM states.
package qkd_pkg;

    localparam int SYMS_PER_WORD = 8;
    localparam int WORD_W        = 16;
    localparam int SYM_W         = 2;
    localparam int CNT_W         = 3;
    localparam int LEN_W         = 12;

    typedef struct packed {
        logic basis;
        logic value;
    } qkd_sym_t;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_STALL = 1'b1
    } qkd_state_e;

endpackage

// File: rtl/qkd_sym_packer.sv
// rtl/qkd_sym_packer.sv - packs 2-bit detector symbols into 16-bit words
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   accept_i, sym_i    symbol handshake already qualified by the top
//   flush_i            close the current word early (zero-padded)
//   pending_o          at least one symbol held in the pack register
//   word_valid_o       one-cycle pulse, word_o is ready to be written
//   word_last_o        the word was produced by a flush (bank must close)
//   word_o             packed word, symbol k in bits [2k+1:2k]
module qkd_sym_packer
    import qkd_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              accept_i,
    input  qkd_sym_t          sym_i,
    input  logic              flush_i,
    output logic              pending_o,
    output logic              word_valid_o,
    output logic              word_last_o,
    output logic [WORD_W-1:0] word_o
);

    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [WORD_W-1:0] word_q;
    logic              valid_q, last_q;
    logic              fire;

    // A symbol accepted in the same cycle as a flush is merged in before the word is emitted.
    always_comb begin
        sreg_d = sreg_q;
        for (int k = 0; k < SYMS_PER_WORD; k++) begin
            if (accept_i && cnt_q == CNT_W'(k)) begin
                sreg_d[2*k +: SYM_W] = sym_i;
            end
        end
        fire = (accept_i && cnt_q == CNT_W'(SYMS_PER_WORD-1))
             || (flush_i && (accept_i || cnt_q != '0));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sreg_q  <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= fire;
            last_q  <= fire && flush_i;
            if (fire) begin
                word_q <= sreg_d;
                sreg_q <= '0;
                cnt_q  <= '0;
            end else if (accept_i) begin
                sreg_q <= sreg_d;
                cnt_q  <= cnt_q + 1'b1;
            end
        end
    end

    assign pending_o    = (cnt_q != '0);
    assign word_valid_o = valid_q;
    assign word_last_o  = last_q;
    assign word_o       = word_q;

endmodule

// File: rtl/qkd_buf_writer.sv
// rtl/qkd_buf_writer.sv - double-banked detector symbol buffer writer
// Optional feature macro: QKD_BUF_OVF_CNT_EN (dropped-offer counter; ovf_cnt tied to 0 otherwise).
// Ports:
//   clk_clk, reset_reset_n             clock, asynchronous active-low reset
//   det_valid/det_sym/det_ready        detector symbol stream
//   flush                              close the active bank early
//   bank_release, bank_full            host handshake per bank
//   bank_len0, bank_len1               word count of each closed bank
//   mem1_*, mem2_*                     bank 0 / bank 1 write ports
//   ovf_cnt                            symbols offered while not ready
module qkd_buf_writer
    import qkd_pkg::*;
#(
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = 11
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              det_valid,
    input  logic [1:0]        det_sym,
    output logic              det_ready,
    input  logic              flush,
    input  logic [1:0]        bank_release,
    output logic [1:0]        bank_full,
    output logic [LEN_W-1:0]  bank_len0,
    output logic [LEN_W-1:0]  bank_len1,
    output logic [ADDR_W-1:0] mem1_address,
    output logic [WORD_W-1:0] mem1_writedata,
    output logic              mem1_write,
    output logic              mem1_chipselect,
    output logic              mem1_clken,
    output logic [1:0]        mem1_byteenable,
    output logic [ADDR_W-1:0] mem2_address,
    output logic [WORD_W-1:0] mem2_writedata,
    output logic              mem2_write,
    output logic              mem2_chipselect,
    output logic              mem2_clken,
    output logic [1:0]        mem2_byteenable,
    output logic [15:0]       ovf_cnt
);

    qkd_state_e        state_q, state_d;
    logic              ready_q, ready_d;
    logic              active_q, active_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        full_q, full_d;
    logic [LEN_W-1:0]  len0_q, len0_d, len1_q, len1_d;
    logic [LEN_W-1:0]  close_len;

    logic              accept, wr, pk_last, pk_pending;
    logic [WORD_W-1:0] pk_word;
    logic              closing_now, flush_ok, flush_empty, close;

    assign accept = det_valid && ready_q;

    // A bank already closing this cycle has met the purpose of a flush, so the flush is dropped.
    assign closing_now = wr && (pk_last || addr_q == ADDR_W'(DEPTH-1));
    assign flush_ok    = flush && (state_q == ST_FILL) && !closing_now;
    assign flush_empty = flush_ok && !accept && !pk_pending;
    // An empty flush still closes when a word is being written this cycle (that word counts).
    assign close       = closing_now || (flush_empty && (wr || addr_q != '0));
    assign close_len   = LEN_W'(addr_q) + LEN_W'(wr);

    qkd_sym_packer u_packer (
        .clk_i        (clk_clk),
        .rst_ni       (reset_reset_n),
        .accept_i     (accept),
        .sym_i        (qkd_sym_t'(det_sym)),
        .flush_i      (flush_ok),
        .pending_o    (pk_pending),
        .word_valid_o (wr),
        .word_last_o  (pk_last),
        .word_o       (pk_word)
    );

    always_comb begin
        addr_d   = addr_q;
        active_d = active_q;
        len0_d   = len0_q;
        len1_d   = len1_q;
        // Releases apply first so that a set of the same bank in this cycle wins.
        full_d   = full_q & ~bank_release;
        if (close) begin
            addr_d           = '0;
            active_d         = ~active_q;
            full_d[active_q] = 1'b1;
            if (active_q) len1_d = close_len;
            else          len0_d = close_len;
        end else if (wr) begin
            addr_d = addr_q + 1'b1;
        end
        state_d = full_d[active_d] ? ST_STALL : ST_FILL;
        ready_d = (state_d == ST_FILL);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q  <= ST_FILL;
            ready_q  <= 1'b0;
            active_q <= 1'b0;
            addr_q   <= '0;
            full_q   <= '0;
            len0_q   <= '0;
            len1_q   <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            active_q <= active_d;
            addr_q   <= addr_d;
            full_q   <= full_d;
            len0_q   <= len0_d;
            len1_q   <= len1_d;
        end
    end

    assign det_ready = ready_q;
    assign bank_full = full_q;
    assign bank_len0 = len0_q;
    assign bank_len1 = len1_q;

    assign mem1_write      = wr && !active_q;
    assign mem1_chipselect = mem1_write;
    assign mem1_clken      = mem1_write;
    assign mem1_byteenable = {2{mem1_write}};
    assign mem1_address    = active_q ? '0 : addr_q;
    assign mem1_writedata  = mem1_write ? pk_word : '0;

    assign mem2_write      = wr && active_q;
    assign mem2_chipselect = mem2_write;
    assign mem2_clken      = mem2_write;
    assign mem2_byteenable = {2{mem2_write}};
    assign mem2_address    = active_q ? addr_q : '0;
    assign mem2_writedata  = mem2_write ? pk_word : '0;

`ifdef QKD_BUF_OVF_CNT_EN
    logic [15:0] ovf_q;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ovf_q <= '0;
        end else if (det_valid && !ready_q && ovf_q != 16'hFFFF) begin
            ovf_q <= ovf_q + 16'd1;
        end
    end

    assign ovf_cnt = ovf_q;
`else
    assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_qkd_buf_writer.sv
// tb/tb_qkd_buf_writer.sv - scoreboard testbench for qkd_buf_writer
module tb_qkd_buf_writer;

    localparam int DEPTH  = 2048;
    localparam int ADDR_W = 11;

    logic              clk;
    logic              rst_n;
    logic              det_valid;
    logic [1:0]        det_sym;
    logic              det_ready;
    logic              flush;
    logic [1:0]        bank_release;
    logic [1:0]        bank_full;
    logic [11:0]       bank_len0, bank_len1;
    logic [ADDR_W-1:0] mem1_address, mem2_address;
    logic [15:0]       mem1_writedata, mem2_writedata;
    logic              mem1_write, mem1_chipselect, mem1_clken;
    logic              mem2_write, mem2_chipselect, mem2_clken;
    logic [1:0]        mem1_byteenable, mem2_byteenable;
    logic [15:0]       ovf_cnt;

    qkd_buf_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_clk         (clk),
        .reset_reset_n   (rst_n),
        .det_valid       (det_valid),
        .det_sym         (det_sym),
        .det_ready       (det_ready),
        .flush           (flush),
        .bank_release    (bank_release),
        .bank_full       (bank_full),
        .bank_len0       (bank_len0),
        .bank_len1       (bank_len1),
        .mem1_address    (mem1_address),
        .mem1_writedata  (mem1_writedata),
        .mem1_write      (mem1_write),
        .mem1_chipselect (mem1_chipselect),
        .mem1_clken      (mem1_clken),
        .mem1_byteenable (mem1_byteenable),
        .mem2_address    (mem2_address),
        .mem2_writedata  (mem2_writedata),
        .mem2_write      (mem2_write),
        .mem2_chipselect (mem2_chipselect),
        .mem2_clken      (mem2_clken),
        .mem2_byteenable (mem2_byteenable),
        .ovf_cnt         (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model of the expected write stream and bank status.
    logic [31:0] exp_q[$];
    int          m_bank, m_addr, m_cnt;
    logic [15:0] m_word;
    logic [1:0]  m_full;
    logic [11:0] m_len[2];

    function automatic void model_clear();
        exp_q.delete();
        m_bank = 0; m_addr = 0; m_cnt = 0; m_word = '0; m_full = '0;
        m_len[0] = '0; m_len[1] = '0;
    endfunction

    function automatic void model_close();
        m_full[m_bank] = 1'b1;
        m_len[m_bank]  = 12'(m_addr);
        m_bank         = m_bank ^ 1;
        m_addr         = 0;
    endfunction

    function automatic void model_push();
        exp_q.push_back({4'b0, m_bank[0], m_addr[10:0], m_word});
        m_addr++;
        m_word = '0;
        m_cnt  = 0;
    endfunction

    function automatic void model_sym(input logic [1:0] s);
        m_word[2*m_cnt +: 2] = s;
        m_cnt++;
        if (m_cnt == 8) begin
            model_push();
            if (m_addr == DEPTH) model_close();
        end
    endfunction

    function automatic void model_flush();
        if (m_full[m_bank]) return;
        if (m_cnt > 0) begin
            model_push();
            model_close();
        end else if (m_addr > 0) begin
            model_close();
        end
    endfunction

    logic [4:0] s1, s2;
    assign s1 = {mem1_write, mem1_chipselect, mem1_clken, mem1_byteenable};
    assign s2 = {mem2_write, mem2_chipselect, mem2_clken, mem2_byteenable};

    // Write-port monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        logic [31:0] got;
        if (rst_n) begin
            if (mem1_write || mem2_write) begin
                got = {4'b0, mem2_write,
                       mem2_write ? mem2_address : mem1_address,
                       mem2_write ? mem2_writedata : mem1_writedata};
                check("wr_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("wr_word", got, exp_q.pop_front());
                check("wr_strobes", mem1_write ? s1 : s2, 5'h1F);
                check("wr_other_idle", mem1_write ? s2 : s1, 0);
            end else begin
                check("idle_strobes", {s1, s2}, 0);
            end
        end
    end

    task automatic send(input logic [1:0] s, input logic with_flush);
        int n = 0;
        det_valid = 1'b1;
        det_sym   = s;
        flush     = with_flush;
        model_sym(s);
        if (with_flush) model_flush();
        while (!det_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("send_timeout", n, 0);
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic idle(input int n);
        det_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        model_flush();
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic release_bank(input logic [1:0] mask);
        bank_release = mask;
        @(negedge clk);
        bank_release = 2'b00;
        m_full = m_full & ~mask;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_full"},  bank_full, m_full);
        check({tag, "_len0"},  bank_len0, m_len[0]);
        check({tag, "_len1"},  bank_len1, m_len[1]);
        check({tag, "_ready"}, det_ready, !m_full[m_bank]);
    endtask

    task automatic do_reset();
        det_valid = 1'b0; flush = 1'b0; bank_release = 2'b00;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_ready",  det_ready, 0);
        check("rst_strobe", {s1, s2}, 0);
        check("rst_addr",   {mem1_address, mem2_address}, 0);
        check("rst_wdata",  {mem1_writedata, mem2_writedata}, 0);
        check("rst_full",   bank_full, 0);
        check("rst_len",    {bank_len0, bank_len1}, 0);
        check("rst_ovf",    ovf_cnt, 0);
        check("rst_leftover_exp", exp_q.size(), 0);
        model_clear();
        @(negedge clk);
        check("rst_hold_ready", det_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready_rise", det_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; det_valid = 1'b0; det_sym = 2'b00; flush = 1'b0; bank_release = 2'b00;
        model_clear();
        do_reset();

        // One word 0,1,2,3,0,1,2,3 -> 16'hE4E4 at mem1[0]; stray release ignored.
        release_bank(2'b10);
        check_status("rel_ignored");
        for (int i = 0; i < 8; i++) send(2'(i % 4), 1'b0);
        idle(2);
        check("t1_drained", exp_q.size(), 0);
        // Empty flush at address 1 closes bank 0 without a write.
        pulse_flush();
        idle(2);
        check_status("flush_empty");

        do_reset();
        // Empty flush at address 0 is a no-op.
        pulse_flush();
        idle(2);
        check_status("flush_noop");
        // Three 2'b11 symbols then flush -> 16'h003F, bank 0 closed with length 1.
        for (int i = 0; i < 3; i++) send(2'b11, 1'b0);
        idle(1);
        pulse_flush();
        idle(3);
        check_status("flush_partial");
        // Flush coincident with the third accept: symbol included, bank 1 closes, both full.
        send(2'b10, 1'b0);
        send(2'b01, 1'b0);
        send(2'b11, 1'b1);
        idle(3);
        check_status("flush_coinc");
        pulse_flush();
        idle(2);
        check_status("flush_stall");
        release_bank(2'b01);
        check_status("rel_stall");
        for (int i = 0; i < 8; i++) send(2'($urandom_range(0, 3)), 1'b0);
        idle(2);

        // Reset in the middle of a word discards it.
        for (int i = 0; i < 5; i++) send(2'b01, 1'b0);
        do_reset();
        for (int i = 0; i < 8; i++) send(2'($urandom_range(0, 3)), 1'b0);
        idle(2);

        do_reset();
        // Fill both banks completely.
        for (int w = 0; w < 2*DEPTH; w++) begin
            for (int i = 0; i < 8; i++) send(2'($urandom_range(0, 3)), 1'b0);
            if (w == DEPTH-1) begin
                idle(2);
                check_status("bank0_full");
            end
        end
        idle(3);
        check_status("both_full");
        det_valid = 1'b1;
        det_sym   = 2'b10;
        repeat (10) @(negedge clk);
        det_valid = 1'b0;
        check("stall_ready", det_ready, 0);
`ifdef QKD_BUF_OVF_CNT_EN
        check("ovf_cnt", ovf_cnt, 10);
`else
        check("ovf_cnt", ovf_cnt, 0);
`endif
        release_bank(2'b01);
        check_status("resume");
        for (int i = 0; i < 8; i++) send(2'($urandom_range(0, 3)), 1'b0);
        idle(3);
        check("final_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3ms;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
